// File: rtl/msk_timing_pkg.sv
// Shared timing-recovery constants and helpers for the NCO and the interpolator.
package msk_timing_pkg;

  localparam int unsigned GapW = 4;
  localparam logic [GapW-1:0] GapMax = '1;

  function automatic logic [31:0] calc_w_nom(input int unsigned wnco, input int unsigned sps_log2);
    return 32'd1 << (wnco - sps_log2);
  endfunction

  function automatic logic [31:0] calc_w_min(input int unsigned wnco, input int unsigned sps_log2);
    logic [31:0] w;
    w = calc_w_nom(wnco, sps_log2);
    return w - (w >> 2);
  endfunction

  function automatic logic [31:0] calc_w_max(input int unsigned wnco, input int unsigned sps_log2);
    logic [31:0] w;
    w = calc_w_nom(wnco, sps_log2);
    return w + (w >> 2);
  endfunction

  // An eta at or above one nominal step would scale past unity, so pin mu to all-ones.
  function automatic logic [31:0] mu_saturate(input logic [31:0] mu_raw, input logic sat,
                                              input int unsigned wmu);
    return sat ? ((32'd1 << wmu) - 32'd1) : mu_raw;
  endfunction

endpackage

// File: rtl/timing_nco_mu.sv
// Scales the pre-decrement NCO phase into the fractional interval mu, saturating near unity.
module timing_nco_mu
  import msk_timing_pkg::*;
#(
  parameter int unsigned WNCO     = 24,
  parameter int unsigned SPS_LOG2 = 2,
  parameter int unsigned WMU      = 16
) (
  input  logic [WNCO-1:0] eta_old_i,
  output logic [WMU-1:0]  mu_o
);

  localparam logic [WNCO-1:0] WNom = WNCO'(calc_w_nom(WNCO, SPS_LOG2));

  logic [WNCO-1:0] eta_scaled;
  logic            sat;

  always_comb begin
    eta_scaled = eta_old_i << SPS_LOG2;
    sat        = (eta_old_i >= WNom);
    mu_o       = WMU'(mu_saturate(32'(eta_scaled >> (WNCO - WMU)), sat, WMU));
  end

endmodule

// File: rtl/timing_nco.sv
// Decrementing timing NCO: issues interpolant strobes with mu, guarding against closely spaced
// underflows and clamping the loop-filter-adjusted step.
module timing_nco
  import msk_timing_pkg::*;
#(
  parameter int unsigned WERR       = 18,
  parameter int unsigned WNCO       = 24,
  parameter int unsigned SPS_LOG2   = 2,
  parameter int unsigned CTRL_SHIFT = 4,
  parameter int unsigned WMU        = 16,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid_i,
  input  logic [WERR-1:0] ctrl_i,
  input  logic            ctrl_valid_i,
  output logic            strobe_o,
  output logic [WMU-1:0]  mu_o,
  output logic            skip_o,
  output logic            clamp_o,
  output logic [15:0]     sym_cnt_o
);

  localparam int unsigned WW = WNCO + 2;
  localparam logic signed [WW-1:0] WNom = WW'(calc_w_nom(WNCO, SPS_LOG2));
  localparam logic signed [WW-1:0] WMin = WW'(calc_w_min(WNCO, SPS_LOG2));
  localparam logic signed [WW-1:0] WMax = WW'(calc_w_max(WNCO, SPS_LOG2));
  localparam logic [WNCO-1:0] EtaInit = '1;

  logic [WNCO-1:0]        eta_q, eta_d;
  logic signed [WERR-1:0] ctrl_q, ctrl_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   strobe_q, strobe_d;
  logic                   skip_q, skip_d;
  logic                   clamp_q, clamp_d;
  logic [WMU-1:0]         mu_q, mu_d, mu_calc;
  logic [15:0]            sym_cnt_q, sym_cnt_d;

  logic signed [WW-1:0] ctrl_ext, w_raw, w_step, eta_diff;
  logic                 underflow, gap_ok;

  timing_nco_mu #(
    .WNCO    (WNCO),
    .SPS_LOG2(SPS_LOG2),
    .WMU     (WMU)
  ) u_mu (
    .eta_old_i(eta_q),
    .mu_o     (mu_calc)
  );

  always_comb begin
    ctrl_ext = WW'(ctrl_q);
    w_raw    = WNom + (ctrl_ext <<< CTRL_SHIFT);
    w_step   = w_raw;
    clamp_d  = 1'b0;
    if (w_raw > WMax) begin
      w_step  = WMax;
      clamp_d = 1'b1;
    end else if (w_raw < WMin) begin
      w_step  = WMin;
      clamp_d = 1'b1;
    end
    // Low WNCO bits of the difference already hold the wrapped phase on underflow.
    eta_diff  = $signed({2'b00, eta_q}) - w_step;
    underflow = (eta_diff < 0);
    gap_ok    = (32'(gap_q) >= MIN_GAP);
  end

  always_comb begin
    ctrl_d    = ctrl_valid_i ? $signed(ctrl_i) : ctrl_q;
    eta_d     = eta_q;
    gap_d     = gap_q;
    strobe_d  = 1'b0;
    skip_d    = 1'b0;
    mu_d      = mu_q;
    sym_cnt_d = sym_cnt_q;
    if (in_valid_i) begin
      eta_d = eta_diff[WNCO-1:0];
      gap_d = (gap_q == GapMax) ? gap_q : gap_q + GapW'(1);
      if (underflow) begin
        if (gap_ok) begin
          strobe_d  = 1'b1;
          mu_d      = mu_calc;
          sym_cnt_d = sym_cnt_q + 16'd1;
          gap_d     = GapW'(1);
        end else begin
          skip_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eta_q     <= EtaInit;
      ctrl_q    <= '0;
      gap_q     <= GapMax;
      strobe_q  <= 1'b0;
      skip_q    <= 1'b0;
      clamp_q   <= 1'b0;
      mu_q      <= '0;
      sym_cnt_q <= '0;
    end else begin
      eta_q     <= eta_d;
      ctrl_q    <= ctrl_d;
      gap_q     <= gap_d;
      strobe_q  <= strobe_d;
      skip_q    <= skip_d;
      clamp_q   <= clamp_d;
      mu_q      <= mu_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign strobe_o  = strobe_q;
  assign skip_o    = skip_q;
  assign clamp_o   = clamp_q;
  assign mu_o      = mu_q;
  assign sym_cnt_o = sym_cnt_q;

endmodule

// File: tb/tb_timing_nco.sv
// Bench for timing_nco: default-gap and MIN_GAP=4 instances checked against a behavioural model.
module tb_timing_nco;

  logic        clk = 1'b0;
  logic        reset_n, in_valid_i, ctrl_valid_i;
  logic [17:0] ctrl_i;
  logic        strobe0, skip0, clamp0, strobe1, skip1, clamp1;
  logic [15:0] mu0, sym0, mu1, sym1;

  always #5 clk = ~clk;

  timing_nco dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .ctrl_i(ctrl_i),
    .ctrl_valid_i(ctrl_valid_i), .strobe_o(strobe0), .mu_o(mu0), .skip_o(skip0),
    .clamp_o(clamp0), .sym_cnt_o(sym0)
  );

  timing_nco #(.MIN_GAP(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .ctrl_i(ctrl_i),
    .ctrl_valid_i(ctrl_valid_i), .strobe_o(strobe1), .mu_o(mu1), .skip_o(skip1),
    .clamp_o(clamp1), .sym_cnt_o(sym1)
  );

  typedef struct packed {
    logic        strobe;
    logic        skip;
    logic        clamp;
    logic [15:0] mu;
    logic [15:0] sym;
  } out_t;

  out_t got0, got1;
  assign got0 = {strobe0, skip0, clamp0, mu0, sym0};
  assign got1 = {strobe1, skip1, clamp1, mu1, sym1};

  out_t sb0[$];
  out_t sb1[$];
  int   checks = 0;
  int   failures = 0;

  localparam longint Mod  = 64'h100_0000;
  localparam longint WNom = 64'h40_0000;
  localparam longint WMin = 64'h30_0000;
  localparam longint WMax = 64'h50_0000;

  longint m_eta[2];
  int     m_ctrl[2];
  int     m_gap[2];
  out_t   m_out[2];
  int     min_gap[2] = '{2, 4};

  task automatic model_step(input int k, input logic iv, input logic cv, input int cval,
                            input logic rst);
    longint w, e;
    if (rst) begin
      m_eta[k] = Mod - 1; m_ctrl[k] = 0; m_gap[k] = 15; m_out[k] = '0;
      return;
    end
    w = WNom + longint'(m_ctrl[k]) * 16;
    m_out[k].clamp = (w > WMax) || (w < WMin);
    if (w > WMax) w = WMax;
    else if (w < WMin) w = WMin;
    m_out[k].strobe = 1'b0;
    m_out[k].skip = 1'b0;
    if (iv) begin
      e = m_eta[k] - w;
      if (e < 0 && m_gap[k] >= min_gap[k]) begin
        m_out[k].strobe = 1'b1;
        m_out[k].mu = (m_eta[k] >= WNom) ? 16'hFFFF : 16'(((m_eta[k] * 4) % Mod) >> 8);
        m_out[k].sym = m_out[k].sym + 16'd1;
        m_gap[k] = 1;
      end else begin
        if (e < 0) m_out[k].skip = 1'b1;
        if (m_gap[k] < 15) m_gap[k]++;
      end
      m_eta[k] = (e < 0) ? e + Mod : e;
    end
    if (cv) m_ctrl[k] = cval;
  endtask

  task automatic step(input logic iv, input logic cv, input int cval, input logic rst);
    reset_n = !rst; in_valid_i = iv; ctrl_valid_i = cv; ctrl_i = 18'(cval);
    for (int k = 0; k < 2; k++) model_step(k, iv, cv, cval, rst);
    sb0.push_back(m_out[0]);
    sb1.push_back(m_out[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e0, e1;
    step(1'b1, 1'b1, 'h1234, 1'b1);
    e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 3;
    if (got0 !== e0) begin failures++; $display("FAIL reset dut0 got=%h exp=%h", got0, e0); end
    if (got1 !== e1) begin failures++; $display("FAIL reset dut1 got=%h exp=%h", got1, e1); end
    if (got0 !== out_t'(0)) begin failures++; $display("FAIL reset_zero got=%h exp=0", got0); end
  endtask

  task automatic test_nominal();
    out_t e0, e1;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 3;
      if (got0 !== e0) begin failures++; $display("FAIL nominal dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL nominal dut1 i=%0d got=%h exp=%h", i, got1, e1); end
      if (strobe0 !== (i % 4 == 3)) begin
        failures++; $display("FAIL nominal_period i=%0d got=%b exp=%b", i, strobe0, (i % 4 == 3));
      end
      if (i == 3) begin
        checks++;
        if (mu0 !== 16'hFFFF) begin failures++; $display("FAIL nominal_mu got=%h exp=ffff", mu0); end
      end
    end
    checks++;
    if (sym0 !== 16'd4) begin failures++; $display("FAIL nominal_sym got=%0d exp=4", sym0); end
  endtask

  task automatic test_slow_rate();
    out_t e0, e1;
    int last, n;
    logic iv;
    last = -1; n = 0;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 48; i++) begin
      iv = (i % 3 == 2);
      step(iv, 1'b0, 0, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL slow dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL slow dut1 i=%0d got=%h exp=%h", i, got1, e1); end
      if (strobe0 === 1'b1) begin
        checks++;
        if (iv !== 1'b1) begin failures++; $display("FAIL slow_latency i=%0d got=no_iv exp=iv", i); end
        if (last >= 0) begin
          checks++;
          if (i - last !== 12) begin failures++; $display("FAIL slow_interval got=%0d exp=12", i - last); end
        end
        last = i; n++;
      end
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL slow_count got=%0d exp=4", n); end
  endtask

  task automatic test_clamp();
    out_t e0, e1;
    int n;
    n = 0;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    step(1'b0, 1'b1, 'h1FFFF, 1'b0);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL clamp_pos dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL clamp_pos dut1 i=%0d got=%h exp=%h", i, got1, e1); end
      if (strobe0 === 1'b1) n++;
    end
    checks += 2;
    if (clamp0 !== 1'b1) begin failures++; $display("FAIL clamp_pos_flag got=%b exp=1", clamp0); end
    if (n !== 5) begin failures++; $display("FAIL clamp_pos_rate got=%0d exp=5", n); end
    step(1'b0, 1'b1, -'h20000, 1'b0);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL clamp_neg dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL clamp_neg dut1 i=%0d got=%h exp=%h", i, got1, e1); end
    end
    checks++;
    if (clamp0 !== 1'b1) begin failures++; $display("FAIL clamp_neg_flag got=%b exp=1", clamp0); end
  endtask

  task automatic test_min_gap();
    out_t e1;
    int nskip;
    logic [15:0] sym_prev;
    nskip = 0;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    step(1'b0, 1'b1, 'h1FFFF, 1'b0);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 16; i++) begin
      sym_prev = sym1;
      step(1'b1, 1'b0, 0, 1'b0);
      void'(sb0.pop_front());
      e1 = sb1.pop_front(); checks += 2;
      if (got1 !== e1) begin failures++; $display("FAIL gap dut1 i=%0d got=%h exp=%h", i, got1, e1); end
      if (strobe0 && skip0) begin failures++; $display("FAIL gap_excl got=11 exp=not_both"); end
      if (skip1 === 1'b1) begin
        nskip++; checks++;
        if (strobe1 !== 1'b0 || sym1 !== sym_prev) begin
          failures++; $display("FAIL gap_skip_hold got=%b/%0d exp=0/%0d", strobe1, sym1, sym_prev);
        end
      end
    end
    checks += 2;
    if (nskip !== 2) begin failures++; $display("FAIL gap_skips got=%0d exp=2", nskip); end
    if (sym1 !== 16'd3) begin failures++; $display("FAIL gap_sym got=%0d exp=3", sym1); end
  endtask

  task automatic test_reset_mid();
    out_t e0, e1;
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 'h8000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin void'(sb0.pop_front()); void'(sb1.pop_front()); end
    step(1'b1, 1'b1, 'h1234, 1'b1);
    e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
    if (got0 !== out_t'(0)) begin failures++; $display("FAIL mid_reset_clear got=%h exp=0", got0); end
    if (got1 !== e1) begin failures++; $display("FAIL mid_reset dut1 got=%h exp=%h", got1, e1); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL mid_after dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (strobe0 !== (i == 3)) begin
        failures++; $display("FAIL mid_after_strobe i=%0d got=%b exp=%b", i, strobe0, (i == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t e0, e1;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0), 'h400, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL b2b dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL b2b dut1 i=%0d got=%h exp=%h", i, got1, e1); end
      if (i == 3) begin
        checks++;
        if (strobe0 !== 1'b1 || mu0 !== 16'hFDFF) begin
          failures++; $display("FAIL b2b_old_ctrl got=%b/%h exp=1/fdff", strobe0, mu0);
        end
      end
    end
  endtask

  task automatic test_random();
    out_t e0, e1;
    int cval;
    step(1'b0, 1'b0, 0, 1'b1);
    void'(sb0.pop_front()); void'(sb1.pop_front());
    for (int i = 0; i < 400; i++) begin
      cval = int'($urandom_range(0, 18'h3FFFF)) - 'h20000;
      if ($urandom_range(0, 3) == 0) cval = cval / 8;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), cval, 1'b0);
      e0 = sb0.pop_front(); e1 = sb1.pop_front(); checks += 2;
      if (got0 !== e0) begin failures++; $display("FAIL random dut0 i=%0d got=%h exp=%h", i, got0, e0); end
      if (got1 !== e1) begin failures++; $display("FAIL random dut1 i=%0d got=%h exp=%h", i, got1, e1); end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid_i = 1'b0; ctrl_valid_i = 1'b0; ctrl_i = '0;
    test_reset();
    test_nominal();
    test_slow_rate();
    test_clamp();
    test_min_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timing_nco.md
TIMING_NCO -- requirements
Module: timing_nco

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WERR, 18: width of ctrl_i (loop-filter output).
- WNCO, 24: NCO phase register width; modulus 2^WNCO.
- SPS_LOG2, 2: log2 samples per symbol; W_NOM = 2^(WNCO-SPS_LOG2).
- CTRL_SHIFT, 4: left shift applied to sign-extended ctrl before adding to W_NOM.
- WMU, 16: fractional-interval output width.
- MIN_GAP, 2: minimum input samples between issued strobes.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock.
- reset_n, in, 1: synchronous, active-low reset.
- in_valid_i, in, 1: input sample strobe; the NCO advances once per pulse.
- ctrl_i, in, WERR signed: timing correction from the loop filter.
- ctrl_valid_i, in, 1: one-cycle strobe; latches ctrl_i.
- strobe_o, out, 1: one-cycle symbol (interpolant) strobe.
- mu_o, out, WMU unsigned: fractional interval, valid with strobe_o, held otherwise.
- skip_o, out, 1: one-cycle pulse; underflow suppressed by the gap guard.
- clamp_o, out, 1: high while the current step is clamped.
- sym_cnt_o, out, 16: strobe counter, wraps 0xFFFF->0.

Function
REQ-003 ctrl_q SHALL load ctrl_i on ctrl_valid_i; ctrl_valid_i together with in_valid_i SHALL use the old ctrl_q for that sample.
REQ-004 Step W = W_NOM + (sext(ctrl_q) <<< CTRL_SHIFT), computed at WNCO+2 bits signed.
REQ-005 W SHALL clamp to [W_MIN, W_MAX], W_MIN = W_NOM - W_NOM/4 and W_MAX = W_NOM + W_NOM/4; clamp_o = 1 whenever clamping applies (combinational from ctrl_q, registered).
REQ-006 On in_valid_i: eta_next = eta - W at WNCO+1 bits; if eta_next >= 0, eta <= eta_next; else eta <= eta_next + 2^WNCO (underflow).
REQ-007 Without in_valid_i, eta, gap counter and outputs SHALL hold; strobe_o and skip_o SHALL be 0.
REQ-008 On underflow with gap_cnt >= MIN_GAP: strobe_o = 1 the cycle after in_valid_i (latency 1), and sym_cnt_o increments.
REQ-009 mu_o = bits [WNCO-1 -: WMU] of (eta_old << SPS_LOG2), where eta_old is the pre-decrement value; if eta_old >= W_NOM, mu_o SHALL saturate to all-ones.
REQ-010 On underflow with gap_cnt < MIN_GAP: skip_o = 1, strobe_o = 0, eta wraps normally, and mu_o and sym_cnt_o are unchanged.
REQ-011 gap_cnt counts in_valid_i pulses since the last issued strobe, saturates at 2^4-1, and resets to 1 on an issued strobe.
REQ-012 strobe_o and skip_o SHALL never both be 1.

Reset
REQ-013 With reset_n = 0 at a clk edge:
- eta = 2^WNCO-1; ctrl_q = 0; gap_cnt = saturated max.
- strobe_o = 0, mu_o = 0, skip_o = 0, clamp_o = 0, sym_cnt_o = 0.
REQ-014 Reset SHALL override in_valid_i and ctrl_valid_i in the same cycle; it is legal mid-symbol and the first sample after reset starts from eta = 2^WNCO-1.

Structure
REQ-015 Package msk_timing_pkg SHALL hold the W_NOM/W_MIN/W_MAX derivation functions and the mu saturation function, shared with the interpolator.
REQ-016 One sub-module, timing_nco_mu: combinational eta_old -> mu_o scaling and saturation.
REQ-017 All outputs SHALL be registered; the implementation contains no multipliers or dividers.

Verification (defaults; W_NOM = 0x400000)
REQ-018 Reset, ctrl = 0, in_valid_i every cycle:
- eta runs 0xBFFFFF, 0x7FFFFF, 0x3FFFFF.
- First strobe_o follows the 4th sample with mu_o = 0xFFFF.
- Strobes then repeat every 4 samples; sym_cnt_o increments by 1 each.
REQ-019 in_valid_i every 3rd cycle, ctrl = 0: strobe_o every 12 cycles, always 1 cycle after in_valid_i; no strobes between.
REQ-020 ctrl_i = +0x1FFFF: W clamps to 0x500000, clamp_o = 1, mean strobe period 3.2 samples. ctrl_i = -0x20000: W clamps to 0x300000, clamp_o = 1.
REQ-021 MIN_GAP = 4, ctrl_i = +0x1FFFF: an underflow 3 samples after a strobe gives skip_o = 1, strobe_o = 0, sym_cnt_o unchanged.
REQ-022 reset_n low for 1 cycle mid-symbol (eta = 0x2xxxxx): all outputs clear next cycle; the next strobe follows the 4th subsequent sample.
REQ-023 ctrl_valid_i with in_valid_i in the same cycle, ctrl 0 -> +0x400: that sample uses W = 0x400000; the next uses W = 0x404000.
